// File: rtl/display_monitor.sv
// display_monitor: passive observer of the disp_* bus; measures active-area geometry per frame,
// tracks frame-to-frame lock, and builds a CRC-16-CCITT of the pixels when DISPLAY_MONITOR_CRC_EN is defined.
module display_monitor #(
    parameter int BPC   = 5,
    parameter int CORDW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_hsync,
    input  logic             disp_vsync,
    input  logic             disp_de,
    input  logic             disp_frame,
    input  logic [BPC-1:0]   disp_r,
    input  logic [BPC-1:0]   disp_g,
    input  logic [BPC-1:0]   disp_b,
    output logic [CORDW-1:0] meas_hres,
    output logic [CORDW-1:0] meas_vres,
    output logic [15:0]      frame_crc,
    output logic             frame_done,
    output logic             locked,
    output logic             err_geom
);

    localparam int PXW = 3 * BPC;
    localparam logic [CORDW-1:0] CNT_ZERO = {CORDW{1'b0}};
    localparam logic [CORDW-1:0] CNT_ONE  = {{(CORDW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic             de_q_r;
    logic [CORDW-1:0] run_r, run_s;
    logic [CORDW-1:0] cur_hres_r, cur_hres_s;
    logic [CORDW-1:0] cur_vres_r, cur_vres_s;
    logic             ragged_r, ragged_s;
    logic [CORDW-1:0] meas_hres_r, meas_hres_s;
    logic [CORDW-1:0] meas_vres_r, meas_vres_s;
    logic             frame_done_r, frame_done_s;
    logic             err_geom_r, err_geom_s;
    logic             locked_r;

    logic             active_s;
    logic             line_close_s;
    logic [CORDW-1:0] run_cont_s;
    logic             run_sat_s;
    logic [CORDW-1:0] run_start_s;
    logic [CORDW-1:0] cl_hres_s;
    logic [CORDW-1:0] cl_vres_s;
    logic             cl_ragged_s;
    logic             unused_s;

    assign active_s     = (state_r == ST_MEASURE) || (state_r == ST_LOCKED);
    // A frame pulse also closes a line still open from the previous cycle.
    assign line_close_s = active_s && de_q_r && (!disp_de || disp_frame);
    assign run_start_s  = disp_de ? CNT_ONE : CNT_ZERO;

    // Run-length counter for the current line, saturating at all-ones
    always_comb begin
        run_cont_s = CNT_ZERO;
        run_sat_s  = 1'b0;
        if (!disp_de) begin
            run_cont_s = CNT_ZERO;
        end else if (!de_q_r) begin
            run_cont_s = CNT_ONE;
        end else if (&run_r) begin
            run_cont_s = run_r;
            run_sat_s  = 1'b1;
        end else begin
            run_cont_s = run_r + CNT_ONE;
        end
    end

    // Frame accumulators with the closing line (if any) folded in
    always_comb begin
        cl_hres_s   = cur_hres_r;
        cl_vres_s   = cur_vres_r;
        cl_ragged_s = ragged_r;
        if (line_close_s) begin
            if (cur_vres_r == CNT_ZERO) begin
                cl_hres_s = run_r;
            end else if (run_r != cur_hres_r) begin
                cl_ragged_s = 1'b1;
            end else begin
                cl_ragged_s = ragged_r;
            end
            if (&cur_vres_r) begin
                cl_ragged_s = 1'b1;
            end else begin
                cl_vres_s = cur_vres_r + CNT_ONE;
            end
        end else begin
            cl_hres_s = cur_hres_r;
        end
    end

    // Next-state logic, frame-end latching and lock decision
    always_comb begin
        state_s      = state_r;
        run_s        = run_r;
        cur_hres_s   = cur_hres_r;
        cur_vres_s   = cur_vres_r;
        ragged_s     = ragged_r;
        meas_hres_s  = meas_hres_r;
        meas_vres_s  = meas_vres_r;
        frame_done_s = 1'b0;
        err_geom_s   = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (disp_frame) begin
                    state_s    = ST_MEASURE;
                    run_s      = run_start_s;
                    cur_hres_s = CNT_ZERO;
                    cur_vres_s = CNT_ZERO;
                    ragged_s   = 1'b0;
                end else begin
                    run_s = CNT_ZERO;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (disp_frame) begin
                    meas_hres_s  = cl_hres_s;
                    meas_vres_s  = cl_vres_s;
                    frame_done_s = 1'b1;
                    if (state_r == ST_MEASURE) begin
                        if (!cl_ragged_s && (cl_hres_s != CNT_ZERO) && (cl_vres_s != CNT_ZERO)) begin
                            state_s = ST_LOCKED;
                        end else begin
                            state_s = ST_MEASURE;
                        end
                    end else if (!cl_ragged_s && (cl_hres_s == meas_hres_r) && (cl_vres_s == meas_vres_r)) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s    = ST_MEASURE;
                        err_geom_s = 1'b1;
                    end
                    run_s      = run_start_s;
                    cur_hres_s = CNT_ZERO;
                    cur_vres_s = CNT_ZERO;
                    ragged_s   = 1'b0;
                end else begin
                    run_s      = run_cont_s;
                    cur_hres_s = cl_hres_s;
                    cur_vres_s = cl_vres_s;
                    ragged_s   = cl_ragged_s | run_sat_s;
                end
            end
            default: begin
                state_s = ST_SEARCH;
                run_s   = CNT_ZERO;
            end
        endcase
    end

    // State, accumulator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_SEARCH;
            de_q_r       <= 1'b0;
            run_r        <= CNT_ZERO;
            cur_hres_r   <= CNT_ZERO;
            cur_vres_r   <= CNT_ZERO;
            ragged_r     <= 1'b0;
            meas_hres_r  <= CNT_ZERO;
            meas_vres_r  <= CNT_ZERO;
            frame_done_r <= 1'b0;
            err_geom_r   <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            de_q_r       <= disp_de;
            run_r        <= run_s;
            cur_hres_r   <= cur_hres_s;
            cur_vres_r   <= cur_vres_s;
            ragged_r     <= ragged_s;
            meas_hres_r  <= meas_hres_s;
            meas_vres_r  <= meas_vres_s;
            frame_done_r <= frame_done_s;
            err_geom_r   <= err_geom_s;
            locked_r     <= (state_s == ST_LOCKED);
        end
    end

    assign meas_hres  = meas_hres_r;
    assign meas_vres  = meas_vres_r;
    assign frame_done = frame_done_r;
    assign err_geom   = err_geom_r;
    assign locked     = locked_r;

`ifdef DISPLAY_MONITOR_CRC_EN
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    logic [PXW-1:0] pix_s;
    logic [15:0]    crc_r, crc_s;
    logic [15:0]    frame_crc_r;
    logic           frame_end_s;

    // One CRC-16-CCITT step over a whole pixel word, MSB first
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [PXW-1:0] word);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = PXW - 1; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    assign pix_s       = {disp_r, disp_g, disp_b};
    assign frame_end_s = active_s && disp_frame;

    // CRC restarts on every frame pulse; the pixel on that cycle belongs to the new frame
    always_comb begin
        crc_s = crc_r;
        if (disp_frame) begin
            crc_s = disp_de ? crc16_word(CRC_INIT, pix_s) : CRC_INIT;
        end else if (active_s && disp_de) begin
            crc_s = crc16_word(crc_r, pix_s);
        end else begin
            crc_s = crc_r;
        end
    end

    // CRC accumulator and latched per-frame result
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r       <= CRC_INIT;
            frame_crc_r <= 16'h0000;
        end else begin
            crc_r <= crc_s;
            if (frame_end_s) begin
                frame_crc_r <= crc_r;
            end else begin
                frame_crc_r <= frame_crc_r;
            end
        end
    end

    assign frame_crc = frame_crc_r;
    assign unused_s  = ^{disp_hsync, disp_vsync};
`else
    assign frame_crc = 16'h0000;
    assign unused_s  = ^{disp_hsync, disp_vsync, disp_r, disp_g, disp_b};
`endif

endmodule
